// File: rtl/reg_file_pkg.sv
// Shared constants and state encoding for the parameterised register file.
package reg_file_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } clr_state_e;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: IDLE/CLEARING state and the sweep address counter.
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              clear_i,
    output logic              idle_o,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_i && !stall_i) begin
                    state_d = ST_CLEARING;
                    cnt_d   = '0;
                end
            end
            ST_CLEARING: begin
                // Counter wraps to 0 on the same edge that returns to IDLE.
                if (!stall_i) begin
                    clr_we_o = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign idle_o     = (state_q == ST_IDLE);
    assign busy_o     = (state_q == ST_CLEARING);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_file_param.sv
// Two-read, one-write register file with optional forwarding, hardwired
// zero entry and a stallable sequential clear.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic              BUSYWAIT,
    input  logic              CLEAR,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              CLR_BUSY
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              idle;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_en;
    logic              zero_wr;
    logic              zero1, zero2;
    logic              hit1, hit2;

    reg_file_clr_seq #(
        .ADDR_W(ADDR_W)
    ) u_clr_seq (
        .clk_i     (CLK),
        .rst_ni    (RESET),
        .stall_i   (BUSYWAIT),
        .clear_i   (CLEAR),
        .idle_o    (idle),
        .busy_o    (CLR_BUSY),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr)
    );

    assign zero_wr = (ZERO_REG != 0) && (INADDRESS == '0);
    assign wr_en   = WRITE && !BUSYWAIT && idle && !CLEAR && !zero_wr;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_en) begin
            mem_q[INADDRESS] <= IN;
        end
    end

    assign zero1 = (ZERO_REG != 0) && (OUT1ADDRESS == '0);
    assign zero2 = (ZERO_REG != 0) && (OUT2ADDRESS == '0);
    assign hit1  = (BYPASS != 0) && wr_en && (INADDRESS == OUT1ADDRESS);
    assign hit2  = (BYPASS != 0) && wr_en && (INADDRESS == OUT2ADDRESS);

    // Reads are masked during reset so forwarding cannot leak IN.
    assign OUT1 = (!RESET || zero1) ? '0 : hit1 ? IN : mem_q[OUT1ADDRESS];
    assign OUT2 = (!RESET || zero2) ? '0 : hit2 ? IN : mem_q[OUT2ADDRESS];

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench: three configurations driven in parallel and checked
// against a behavioural model of the register file.
module tb_reg_file_param;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic       WRITE, BUSYWAIT, CLEAR;
    logic [2:0] OUT1ADDRESS, OUT2ADDRESS;

    logic [7:0] o1_a, o2_a, o1_n, o2_n, o1_z, o2_z;
    logic       cb_a, cb_n, cb_z;

    int vectors = 0;
    int errs    = 0;
    int busy_seen;

    always #5 CLK = ~CLK;

    reg_file_param #(.BYPASS(1), .ZERO_REG(0)) dut_a (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS),
        .WRITE(WRITE), .BUSYWAIT(BUSYWAIT), .CLEAR(CLEAR),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(o1_a), .OUT2(o2_a), .CLR_BUSY(cb_a)
    );

    reg_file_param #(.BYPASS(0), .ZERO_REG(0)) dut_n (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS),
        .WRITE(WRITE), .BUSYWAIT(BUSYWAIT), .CLEAR(CLEAR),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(o1_n), .OUT2(o2_n), .CLR_BUSY(cb_n)
    );

    reg_file_param #(.BYPASS(1), .ZERO_REG(1)) dut_z (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS),
        .WRITE(WRITE), .BUSYWAIT(BUSYWAIT), .CLEAR(CLEAR),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(o1_z), .OUT2(o2_z), .CLR_BUSY(cb_z)
    );

    typedef struct packed {
        logic [2:0][7:0] o1;
        logic [2:0][7:0] o2;
        logic [2:0]      cb;
    } exp_t;

    exp_t q[$];

    // Model: index 0 = bypass, 1 = no bypass, 2 = bypass + zero reg
    logic [7:0] m [3][8];
    logic       mbusy;
    logic [2:0] mcnt;
    bit         mbyp [3] = '{1'b1, 1'b0, 1'b1};
    bit         mzr  [3] = '{1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic eff_wr(input int i);
        return RESET && WRITE && !BUSYWAIT && !mbusy && !CLEAR
               && !(mzr[i] && INADDRESS == 3'd0);
    endfunction

    function automatic logic [7:0] mread(input int i, input logic [2:0] a);
        if (!RESET) return 8'h00;
        if (mzr[i] && a == 3'd0) return 8'h00;
        if (mbyp[i] && eff_wr(i) && INADDRESS == a) return IN;
        return m[i][a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 8; k++) m[i][k] = 8'h00;
        mbusy = 1'b0;
        mcnt  = 3'd0;
    endtask

    task automatic model_edge();
        logic we [3];
        for (int i = 0; i < 3; i++) we[i] = eff_wr(i);
        if (!RESET || BUSYWAIT) return;
        if (mbusy) begin
            for (int i = 0; i < 3; i++) m[i][mcnt] = 8'h00;
            if (mcnt == 3'd7) mbusy = 1'b0;
            mcnt = mcnt + 3'd1;
        end else if (CLEAR) begin
            mbusy = 1'b1;
            mcnt  = 3'd0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (we[i]) m[i][INADDRESS] = IN;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.o1[i] = mread(i, OUT1ADDRESS);
            e.o2[i] = mread(i, OUT2ADDRESS);
            e.cb[i] = RESET ? mbusy : 1'b0;
        end
        q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        logic [2:0][7:0] g1, g2;
        logic [2:0]      gc;
        g1 = {o1_z, o1_n, o1_a};
        g2 = {o2_z, o2_n, o2_a};
        gc = {cb_z, cb_n, cb_a};
        if (cb_a) busy_seen++;
        if (q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_out1_%0d", tag, i), g1[i], e.o1[i]);
            chk($sformatf("%s_out2_%0d", tag, i), g2[i], e.o2[i]);
            chk($sformatf("%s_busy_%0d", tag, i), gc[i], e.cb[i]);
        end
    endtask

    task automatic step(input string tag, input logic wr,
                        input logic [2:0] wa, input logic [7:0] wd,
                        input logic bw, input logic clr,
                        input logic [2:0] a1, input logic [2:0] a2);
        @(negedge CLK);
        WRITE = wr; INADDRESS = wa; IN = wd;
        BUSYWAIT = bw; CLEAR = clr;
        OUT1ADDRESS = a1; OUT2ADDRESS = a2;
        push_exp();
        #2;
        pop_cmp(tag);
        model_edge();
    endtask

    task automatic idle_inputs();
        WRITE = 1'b0; CLEAR = 1'b0; BUSYWAIT = 1'b0;
        IN = 8'h00; INADDRESS = 3'd0;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int k = 0; k < 8; k++)
            step("fill", 1'b1, 3'(k), base + 8'(k), 1'b0, 1'b0,
                 3'(k), 3'(k + 7));
    endtask

    initial begin
        RESET = 1'b0;
        idle_inputs();
        OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd5;
        model_reset();
        #3;
        push_exp();
        pop_cmp("reset");
        @(negedge CLK);
        RESET = 1'b1;

        // forwarding vs registered write
        step("byp_wr", 1'b1, 3'd2, 8'h1F, 1'b0, 1'b0, 3'd2, 3'd2);
        step("byp_rd", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd2, 3'd1);
        step("stall_wr", 1'b1, 3'd3, 8'h55, 1'b1, 1'b0, 3'd3, 3'd2);
        step("stall_rd", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd3, 3'd3);
        step("zero_wr", 1'b1, 3'd0, 8'hAA, 1'b0, 1'b0, 3'd0, 3'd0);
        step("zero_rd", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0);

        // full sweep with a simultaneous write and ignored traffic
        fill(8'h10);
        busy_seen = 0;
        step("clr_wr", 1'b1, 3'd5, 8'hEE, 1'b0, 1'b1, 3'd5, 3'd0);
        for (int k = 0; k < 8; k++)
            step("sweep", 1'b1, 3'd1, 8'h77, 1'b0, 1'(k % 2),
                 3'(k), 3'(7 - k));
        step("post", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd1, 3'd5);
        chk("sweep_len", busy_seen, 8);

        // stalled sweep
        fill(8'h40);
        busy_seen = 0;
        step("clr2", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd0, 3'd4);
        for (int k = 0; k < 11; k++)
            step("sweep2", 1'b0, 3'd0, 8'h00, 1'(k >= 3 && k < 6), 1'b0,
                 3'(k), 3'd7);
        step("post2", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd6, 3'd7);
        chk("stall_len", busy_seen, 11);

        // reset in the middle of a sweep
        fill(8'h80);
        step("clr3", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd6, 3'd7);
        for (int k = 0; k < 4; k++)
            step("sweep3", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd6, 3'd7);
        @(negedge CLK);
        idle_inputs();
        #1;
        RESET = 1'b0;
        #1;
        model_reset();
        push_exp();
        pop_cmp("mid_rst");
        @(negedge CLK);
        RESET = 1'b1;
        step("rel_wr", 1'b1, 3'd6, 8'h3C, 1'b0, 1'b0, 3'd6, 3'd7);
        step("rel_rd", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd6, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
